// File: rtl/dbg_commit_trace_if.sv
// Commit-trace bus: multi-lane retire port into the trace buffer plus the
// single-entry valid/ready drain port toward the host-side consumer.
interface dbg_commit_trace_if #(
    parameter int XLEN = 32,
    parameter int NCH  = 2,
    parameter int SEQW = 32
);
    logic [NCH-1:0]      cmt_valid;
    logic [NCH*XLEN-1:0] cmt_pc;
    logic [NCH*32-1:0]   cmt_inst;
    logic [NCH-1:0]      cmt_wen;
    logic [NCH*5-1:0]    cmt_rd;
    logic [NCH*XLEN-1:0] cmt_wdata;
    logic [NCH-1:0]      cmt_brk;
    logic [NCH-1:0]      cmt_ivd;
    logic                cmt_ready;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [31:0]         out_inst;
    logic                out_wen;
    logic [4:0]          out_rd;
    logic [XLEN-1:0]     out_wdata;
    logic [SEQW-1:0]     out_seq;
    logic [1:0]          out_cause;

    // master is the core/host side; slave is the trace buffer
    modport master (
        output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata, cmt_brk, cmt_ivd,
        input  cmt_ready,
        input  out_valid, out_pc, out_inst, out_wen, out_rd, out_wdata, out_seq, out_cause,
        output out_ready
    );

    modport slave (
        input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata, cmt_brk, cmt_ivd,
        output cmt_ready,
        output out_valid, out_pc, out_inst, out_wen, out_rd, out_wdata, out_seq, out_cause,
        input  out_ready
    );
endinterface

// File: rtl/dbg_commit_trace.sv
// Commit-trace ring buffer: packs up to NCH retirements per cycle, drains them
// over a valid/ready port and halts the core after an ebreak/invalid retirement.
module dbg_commit_trace #(
    parameter int XLEN      = 32,
    parameter int NCH       = 2,
    parameter int DEPTH     = 16,
    parameter int SEQW      = 32,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    dbg_commit_trace_if.slave        bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_cnt,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [XLEN-1:0]          halt_pc,
    input  logic                     resume
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic [1:0] cause_enc(input logic brk, input logic ivd);
        logic [1:0] c;
        if (brk) begin
            c = 2'b01;
        end else if (ivd) begin
            c = 2'b10;
        end else begin
            c = 2'b00;
        end
        return c;
    endfunction

    state_t            state_r, state_next_s;
    logic [PW-1:0]     head_r, tail_r;
    logic [LW-1:0]     level_r;
    logic [SEQW-1:0]   seq_r;
    logic [15:0]       drop_cnt_r;
    logic              halted_r;
    logic [1:0]        halt_cause_r;
    logic [XLEN-1:0]   halt_pc_r;
    logic              cmt_ready_r;

    logic [XLEN-1:0]   mem_pc_r    [DEPTH];
    logic [31:0]       mem_inst_r  [DEPTH];
    logic              mem_wen_r   [DEPTH];
    logic [4:0]        mem_rd_r    [DEPTH];
    logic [XLEN-1:0]   mem_wdata_r [DEPTH];
    logic [SEQW-1:0]   mem_seq_r   [DEPTH];
    logic [1:0]        mem_cause_r [DEPTH];

    logic              wr_en_s   [NCH];
    logic [PW-1:0]     wr_slot_s [NCH];
    logic [SEQW-1:0]   wr_seq_s  [NCH];
    logic [LW-1:0]     push_cnt_s;
    logic              stop_s;
    logic              hit_s;
    logic [1:0]        hit_cause_s;
    logic [XLEN-1:0]   hit_pc_s;

    logic              out_valid_s;
    logic              pop_s;
    logic [LW-1:0]     avail_s;
    logic [LW-1:0]     drop_s;
    logic [LW-1:0]     level_next_s;
    logic [PW-1:0]     head_next_s;
    logic [PW-1:0]     tail_next_s;
    logic [16:0]       drop_sum_s;
    logic [15:0]       drop_cnt_next_s;
    logic              ready_next_s;

    // Lane packing: valid lanes go to consecutive slots; a brk/ivd lane closes the group
    always_comb begin
        stop_s      = 1'b0;
        push_cnt_s  = {LW{1'b0}};
        hit_s       = 1'b0;
        hit_cause_s = 2'b00;
        hit_pc_s    = {XLEN{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            wr_en_s[i]   = 1'b0;
            wr_slot_s[i] = {PW{1'b0}};
            wr_seq_s[i]  = {SEQW{1'b0}};
            if (cmt_ready_r && bus.cmt_valid[i] && !stop_s) begin
                wr_en_s[i]   = 1'b1;
                wr_slot_s[i] = tail_r + push_cnt_s[PW-1:0];
                wr_seq_s[i]  = seq_r + SEQW'(push_cnt_s);
                push_cnt_s   = push_cnt_s + LW'(1);
                if (bus.cmt_brk[i] || bus.cmt_ivd[i]) begin
                    stop_s      = 1'b1;
                    hit_s       = 1'b1;
                    hit_cause_s = cause_enc(bus.cmt_brk[i], bus.cmt_ivd[i]);
                    hit_pc_s    = bus.cmt_pc[i*XLEN +: XLEN];
                end else begin
                    stop_s = stop_s;
                end
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
    end

    // Occupancy bookkeeping: pop first, then push; overflow advances head past the oldest
    always_comb begin
        out_valid_s  = (level_r != {LW{1'b0}});
        pop_s        = out_valid_s && bus.out_ready;
        avail_s      = LW'(DEPTH) - level_r + {{(LW-1){1'b0}}, pop_s};
        if (push_cnt_s > avail_s) begin
            drop_s = push_cnt_s - avail_s;
        end else begin
            drop_s = {LW{1'b0}};
        end
        level_next_s = level_r + push_cnt_s - {{(LW-1){1'b0}}, pop_s} - drop_s;
        head_next_s  = head_r + {{(PW-1){1'b0}}, pop_s} + drop_s[PW-1:0];
        tail_next_s  = tail_r + push_cnt_s[PW-1:0];
        drop_sum_s   = {1'b0, drop_cnt_r} + 17'(drop_s);
        if (drop_sum_s[16]) begin
            drop_cnt_next_s = 16'hFFFF;
        end else begin
            drop_cnt_next_s = drop_sum_s[15:0];
        end
    end

    // Halt FSM next state and the commit-ready flag it implies for the next cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (hit_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (level_r == {LW{1'b0}}) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
        if (state_next_s != ST_RUN) begin
            ready_next_s = 1'b0;
        end else if (OVERWRITE != 0) begin
            ready_next_s = 1'b1;
        end else begin
            ready_next_s = ((LW'(DEPTH) - level_next_s) >= LW'(NCH));
        end
    end

    // Control state, pointers, counters and halt capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_RUN;
            head_r       <= {PW{1'b0}};
            tail_r       <= {PW{1'b0}};
            level_r      <= {LW{1'b0}};
            seq_r        <= {SEQW{1'b0}};
            drop_cnt_r   <= 16'h0000;
            halted_r     <= 1'b0;
            halt_cause_r <= 2'b00;
            halt_pc_r    <= {XLEN{1'b0}};
            cmt_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            level_r     <= level_next_s;
            seq_r       <= seq_r + SEQW'(push_cnt_s);
            drop_cnt_r  <= drop_cnt_next_s;
            halted_r    <= (state_next_s == ST_HALTED);
            cmt_ready_r <= ready_next_s;
            if ((state_r == ST_RUN) && hit_s) begin
                halt_cause_r <= hit_cause_s;
                halt_pc_r    <= hit_pc_s;
            end
        end
    end

    // Entry storage; cleared on reset so seq/cause read zero from an empty buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_pc_r[d]    <= {XLEN{1'b0}};
                mem_inst_r[d]  <= 32'h0000_0000;
                mem_wen_r[d]   <= 1'b0;
                mem_rd_r[d]    <= 5'd0;
                mem_wdata_r[d] <= {XLEN{1'b0}};
                mem_seq_r[d]   <= {SEQW{1'b0}};
                mem_cause_r[d] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en_s[i]) begin
                    mem_pc_r[wr_slot_s[i]]    <= bus.cmt_pc[i*XLEN +: XLEN];
                    mem_inst_r[wr_slot_s[i]]  <= bus.cmt_inst[i*32 +: 32];
                    mem_wen_r[wr_slot_s[i]]   <= bus.cmt_wen[i];
                    mem_rd_r[wr_slot_s[i]]    <= bus.cmt_rd[i*5 +: 5];
                    mem_wdata_r[wr_slot_s[i]] <= bus.cmt_wdata[i*XLEN +: XLEN];
                    mem_seq_r[wr_slot_s[i]]   <= wr_seq_s[i];
                    mem_cause_r[wr_slot_s[i]] <= cause_enc(bus.cmt_brk[i], bus.cmt_ivd[i]);
                end
            end
        end
    end

    assign bus.cmt_ready = cmt_ready_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc    = mem_pc_r[head_r];
    assign bus.out_inst  = mem_inst_r[head_r];
    assign bus.out_wen   = mem_wen_r[head_r];
    assign bus.out_rd    = mem_rd_r[head_r];
    assign bus.out_wdata = mem_wdata_r[head_r];
    assign bus.out_seq   = mem_seq_r[head_r];
    assign bus.out_cause = mem_cause_r[head_r];

    assign level      = level_r;
    assign drop_cnt   = drop_cnt_r;
    assign halted     = halted_r;
    assign halt_cause = halt_cause_r;
    assign halt_pc    = halt_pc_r;
endmodule

// File: tb/tb_dbg_commit_trace.sv
// Directed bench for dbg_commit_trace: back-pressure instance (u_dut0) and
// overwrite instance (u_dut1), expected values worked out by hand.
module tb_dbg_commit_trace;
    logic        clk;
    logic        reset;
    logic        resume0, resume1;
    logic [4:0]  level0, level1;
    logic [15:0] drop0, drop1;
    logic        halted0, halted1;
    logic [1:0]  hcause0, hcause1;
    logic [31:0] hpc0, hpc1;
    int          n_chk;
    int          n_bad;

    dbg_commit_trace_if #(.XLEN(32), .NCH(2), .SEQW(32)) b0 ();
    dbg_commit_trace_if #(.XLEN(32), .NCH(2), .SEQW(32)) b1 ();

    dbg_commit_trace #(.XLEN(32), .NCH(2), .DEPTH(16), .SEQW(32), .OVERWRITE(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(b0), .level(level0), .drop_cnt(drop0),
        .halted(halted0), .halt_cause(hcause0), .halt_pc(hpc0), .resume(resume0)
    );

    dbg_commit_trace #(.XLEN(32), .NCH(2), .DEPTH(16), .SEQW(32), .OVERWRITE(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(b1), .level(level1), .drop_cnt(drop1),
        .halted(halted1), .halt_cause(hcause1), .halt_pc(hpc1), .resume(resume1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] brk, input logic [1:0] ivd);
        b0.cmt_valid = v;
        b0.cmt_pc    = {pc1, pc0};
        b0.cmt_inst  = {32'h0010_0093, 32'h0000_0013};
        b0.cmt_wen   = 2'b11;
        b0.cmt_rd    = {5'd2, 5'd1};
        b0.cmt_wdata = {pc1 ^ 32'h5A5A_5A5A, pc0 ^ 32'hA5A5_A5A5};
        b0.cmt_brk   = brk;
        b0.cmt_ivd   = ivd;
    endtask

    task automatic drv1(input logic v, input logic [31:0] pc0);
        b1.cmt_valid = {1'b0, v};
        b1.cmt_pc    = {32'h0000_0000, pc0};
        b1.cmt_inst  = {32'h0000_0000, 32'h0000_0013};
        b1.cmt_wen   = 2'b00;
        b1.cmt_rd    = 10'd0;
        b1.cmt_wdata = 64'd0;
        b1.cmt_brk   = 2'b00;
        b1.cmt_ivd   = 2'b00;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b0;
        resume0 = 1'b0;
        resume1 = 1'b0;
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        drv1(1'b0, 32'h0);
        b0.out_ready = 1'b0;
        b1.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_level", level0, 5'd0);
        chk("rst_out_valid", b0.out_valid, 1'b0);
        chk("rst_cmt_ready", b0.cmt_ready, 1'b1);
        chk("rst_halted", halted0, 1'b0);
        chk("rst_drop", drop0, 16'h0);
        chk("rst_out_seq", b0.out_seq, 32'h0);
        chk("rst_out_cause", b0.out_cause, 2'b00);
        chk("rst_halt_cause", hcause0, 2'b00);
        reset = 1'b1;
        tick();

        // two lanes in one cycle, drained back to back
        b0.out_ready = 1'b1;
        drv0(2'b11, 32'h8000_0000, 32'h8000_0004, 2'b00, 2'b00);
        #1;
        chk("no_bypass", b0.out_valid, 1'b0);
        tick();
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("t1_level", level0, 5'd2);
        chk("t1_seq0", b0.out_seq, 32'd0);
        chk("t1_pc0", b0.out_pc, 32'h8000_0000);
        chk("t1_wdata0", b0.out_wdata, 32'h25A5_A5A5);
        chk("t1_inst0", b0.out_inst, 32'h0000_0013);
        tick();
        chk("t1_seq1", b0.out_seq, 32'd1);
        chk("t1_pc1", b0.out_pc, 32'h8000_0004);
        chk("t1_rd1", b0.out_rd, 5'd2);
        chk("t1_wdata1", b0.out_wdata, 32'hDA5A_5A5E);
        tick();
        chk("t1_empty", b0.out_valid, 1'b0);

        // back-pressure: fill to 15 and watch cmt_ready fall
        b0.out_ready = 1'b0;
        drv0(2'b01, 32'h8000_1000, 32'h0, 2'b00, 2'b00);
        tick();
        drv0(2'b11, 32'h8000_1004, 32'h8000_1008, 2'b00, 2'b00);
        for (int k = 0; k < 6; k++) tick();
        chk("t2_level13", level0, 5'd13);
        chk("t2_ready13", b0.cmt_ready, 1'b1);
        tick();
        chk("t2_level15", level0, 5'd15);
        chk("t2_ready15", b0.cmt_ready, 1'b0);
        b0.out_ready = 1'b1;
        tick();
        b0.out_ready = 1'b0;
        chk("t2_level14", level0, 5'd14);
        chk("t2_ready14", b0.cmt_ready, 1'b1);
        chk("t2_head_seq", b0.out_seq, 32'd3);
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        b0.out_ready = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk("t2_drained", level0, 5'd0);
        b0.out_ready = 1'b0;

        // ebreak on lane 0 discards lane 1 and starts the drain
        drv0(2'b11, 32'h8000_0010, 32'h8000_0014, 2'b01, 2'b00);
        tick();
        chk("t4_level", level0, 5'd1);
        chk("t4_cause", b0.out_cause, 2'b01);
        chk("t4_seq", b0.out_seq, 32'd17);
        chk("t4_halt_pc", hpc0, 32'h8000_0010);
        chk("t4_halt_cause", hcause0, 2'b01);
        chk("t4_ready_drain", b0.cmt_ready, 1'b0);
        drv0(2'b01, 32'h8000_0018, 32'h0, 2'b00, 2'b00);
        resume0 = 1'b1;
        tick();
        resume0 = 1'b0;
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("t4_drain_ignores", level0, 5'd1);
        chk("t4_drain_not_halted", halted0, 1'b0);
        b0.out_ready = 1'b1;
        tick();
        chk("t4_level0", level0, 5'd0);
        chk("t4_halt_late", halted0, 1'b0);
        tick();
        chk("t4_halted", halted0, 1'b1);
        chk("t4_ready_halted", b0.cmt_ready, 1'b0);
        resume0 = 1'b1;
        tick();
        resume0 = 1'b0;
        chk("t4_resumed", halted0, 1'b0);
        chk("t4_ready_run", b0.cmt_ready, 1'b1);
        chk("t4_cause_kept", hcause0, 2'b01);

        // brk and ivd on the same lane: brk wins
        drv0(2'b01, 32'h8000_0020, 32'h0, 2'b01, 2'b01);
        tick();
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("t5_both_cause", hcause0, 2'b01);
        chk("t5_both_out_cause", b0.out_cause, 2'b01);
        chk("t5_seq", b0.out_seq, 32'd18);
        tick();
        tick();
        chk("t5_halted", halted0, 1'b1);
        resume0 = 1'b1;
        tick();
        resume0 = 1'b0;

        // fill to 5, ivd on lane 1 enters drain, then reset mid-drain
        b0.out_ready = 1'b0;
        drv0(2'b11, 32'h8000_0030, 32'h8000_0034, 2'b00, 2'b00);
        tick();
        drv0(2'b01, 32'h8000_0038, 32'h0, 2'b00, 2'b00);
        tick();
        drv0(2'b11, 32'h8000_003C, 32'h8000_0040, 2'b00, 2'b10);
        tick();
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("t5_level5", level0, 5'd5);
        chk("t5_ivd_cause", hcause0, 2'b10);
        chk("t5_ivd_pc", hpc0, 32'h8000_0040);
        chk("t5_head_normal", b0.out_cause, 2'b00);
        chk("t5_ready_drain", b0.cmt_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("t6_level", level0, 5'd0);
        chk("t6_out_valid", b0.out_valid, 1'b0);
        chk("t6_halted", halted0, 1'b0);
        chk("t6_ready", b0.cmt_ready, 1'b1);
        chk("t6_halt_cause", hcause0, 2'b00);
        reset = 1'b1;
        drv0(2'b01, 32'h8000_0100, 32'h0, 2'b00, 2'b00);
        tick();
        drv0(2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
        chk("t6_seq_restart", b0.out_seq, 32'd0);
        chk("t6_pc", b0.out_pc, 32'h8000_0100);
        chk("t6_level1", level0, 5'd1);

        // overwrite mode: 20 single-lane pushes into 16 slots
        for (int k = 0; k < 20; k++) begin
            drv1(1'b1, 32'h8000_0000 + 32'(k * 4));
            tick();
        end
        drv1(1'b0, 32'h0);
        chk("t3_level", level1, 5'd16);
        chk("t3_drop", drop1, 16'd4);
        chk("t3_first_seq", b1.out_seq, 32'd4);
        chk("t3_first_pc", b1.out_pc, 32'h8000_0010);
        chk("t3_ready", b1.cmt_ready, 1'b1);
        b1.out_ready = 1'b1;
        drv1(1'b1, 32'h8000_0050);
        tick();
        b1.out_ready = 1'b0;
        chk("t3_pop_push_drop", drop1, 16'd4);
        chk("t3_pop_push_seq", b1.out_seq, 32'd5);
        chk("t3_pop_push_level", level1, 5'd16);
        b1.cmt_valid = 2'b11;
        tick();
        drv1(1'b0, 32'h0);
        chk("t3_dual_drop", drop1, 16'd6);
        chk("t3_dual_seq", b1.out_seq, 32'd7);
        chk("t3_dual_level", level1, 5'd16);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/dbg_commit_trace.md
Name: dbg_commit_trace

Overview:
Parametrised commit-trace buffer for the NPC debugger. It succeeds the single-lane, DPI-driven debug hook with a synthesizable ring buffer. It accepts up to NCH retired instructions per cycle, including PC, instruction word and GPR write. It detects ebreak/invalid-instruction retirements, drains them to a host-side consumer over a valid/ready port, and runs a RUN/DRAIN/HALTED state machine that tells the core to halt.

Parameters:
XLEN, 32, data/PC width
NCH, 2, commit lanes per cycle (1..4)
DEPTH, 16, buffer entries (power of 2, >= NCH)
SEQW, 32, sequence-number width
OVERWRITE, 0, 0 = back-pressure when full; 1 = drop oldest entry when full

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cmt_valid  in  NCH  lane i retires an instruction
cmt_pc  in  NCH*XLEN  PC per lane (lane i at bits [i*XLEN +: XLEN])
cmt_inst  in  NCH*32  instruction word per lane
cmt_wen  in  NCH  GPR write enable per lane
cmt_rd  in  NCH*5  GPR write address per lane
cmt_wdata  in  NCH*XLEN  GPR write data per lane
cmt_brk  in  NCH  lane retires ebreak
cmt_ivd  in  NCH  lane retires an invalid instruction
cmt_ready  out  1  buffer accepts this cycle's commits
out_valid  out  1  head entry available
out_ready  in  1  consumer takes head entry
out_pc, out_inst, out_wen, out_rd, out_wdata  out  XLEN,32,1,5,XLEN  head entry fields
out_seq  out  SEQW  sequence number of head entry
out_cause  out  2  00 normal, 01 brk, 10 ivd
level  out  clog2(DEPTH)+1  current occupancy
drop_cnt  out  16  entries lost in overwrite mode (saturating)
halted  out  1  core must stay halted
halt_cause  out  2  cause latched at halt (01 brk, 10 ivd)
halt_pc  out  XLEN  PC of the halting instruction
resume  in  1  single-cycle pulse; leave HALTED

Behaviour:
- Reset (reset=0, asynchronous): buffer empty, head=tail=0, level=0, seq=0, drop_cnt=0, state RUN, halted=0, halt_cause=0, halt_pc=0, out_valid=0, cmt_ready=1. Reset mid-operation discards all entries.
- Lane packing: valid lanes are written in ascending lane order to consecutive slots from tail. A lane with cmt_brk|cmt_ivd terminates the group; higher lanes in the same cycle are discarded and not counted as drops.
- cause per entry: brk has priority over ivd (both set -> 01).
- cmt_ready: RUN and OVERWRITE=0 -> (DEPTH - level) >= NCH, registered-state only and independent of cmt_valid. RUN and OVERWRITE=1 -> 1. DRAIN/HALTED -> 0.
- Commits are accepted only when cmt_ready=1; cmt_valid with cmt_ready=0 is ignored.
- Overwrite: when free slots are fewer than pushed entries, the oldest entries are advanced past. drop_cnt increases by the number lost and saturates at 16'hFFFF.
- Push/pop in the same cycle: the pop is applied first. level_next = level + pushed - popped - dropped.
- Output: out_* reflect the head slot combinationally. out_valid = (level != 0). Pop happens when out_valid & out_ready. A written entry is visible one cycle after the write edge (zero bypass).
- Pointers wrap modulo DEPTH. seq increments per accepted entry, wraps at 2^SEQW, and includes dropped entries, so gaps are detectable.
- FSM:
  - RUN: an accepted brk/ivd entry latches halt_cause and halt_pc -> DRAIN.
  - DRAIN: cmt_ready=0; consumer continues popping; level==0 -> HALTED, with halted=1 from the next cycle.
  - HALTED: resume -> RUN with halted=0 and halt_cause kept until the next halt. resume in RUN/DRAIN is ignored.
- out_pc/out_inst/out_rd/out_wdata are don't-care when out_valid=0; out_cause and out_seq read 0 after reset.

Test Plan:
- NCH=2, OVERWRITE=0, out_ready=1: lanes 0/1 valid with pc 0x80000000/0x80000004 -> out_seq 0,1 on consecutive cycles, each appearing one cycle after the write edge; level peaks at 2.
- OVERWRITE=0, out_ready=0: push 2/cycle -> cmt_ready drops when level=15 (free 1 < 2). Set out_ready=1 for one pop -> level 14, cmt_ready=1 next cycle.
- OVERWRITE=1, DEPTH=16, out_ready=0: push 20 single-lane entries -> level=16, drop_cnt=4, first out_seq=4.
- Lane 0 pc 0x80000010 with cmt_brk=1, lane 1 valid -> lane 1 discarded, out_cause=01, halt_pc=0x80000010. Drain -> halted=1 one cycle after level hits 0. Pulse resume -> halted=0, cmt_ready=1.
- cmt_brk & cmt_ivd on the same lane -> halt_cause=01. An ivd-only retirement -> halt_cause=10.
- Assert reset=0 mid-drain with level=5 -> level=0, out_valid=0, halted=0, state RUN, seq restarts at 0.
